// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes, ALUOp and ALUControl.
// Pure declarations: no logic, no latency, no flow control.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct3/funct7 to ALUControl decode, zero latency, no flow control;
// flags funct3 values the datapath cannot execute.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic        op5,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_control,
  output logic        funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op5 set) can encode sub; addi's bit 30 is immediate data
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle RISC-V core: lw 5 cycles, beq 3, others 4.
// No flow control; PCWrite/IRWrite/MemWrite are held low while reset_n is low.
module mc_controller
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        illegal
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    pc_update, branch, ir_write, mem_write;
  logic    decode_illegal, funct_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = FETCH;
    pc_update      = 1'b0;
    branch         = 1'b0;
    ir_write       = 1'b0;
    mem_write      = 1'b0;
    AdrSrc         = 1'b0;
    ResultSrc      = 2'b00;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    RegWrite       = 1'b0;
    alu_op         = ALUOP_ADD;
    decode_illegal = 1'b0;
    case (state)
      FETCH: begin
        state_next = DECODE;
        ir_write   = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTER;
          OP_ITYPE:     state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      decode_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB:  RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .op5           (op[5]),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .alu_control   (ALUControl),
    .funct_illegal (funct_illegal)
  );

  // FETCH is the reset state, so the enables it asserts must be masked by reset itself
  assign IRWrite  = ir_write & reset_n;
  assign PCWrite  = reset_n & (pc_update | (branch & Zero));
  assign MemWrite = mem_write & reset_n;
  assign illegal  = decode_illegal | funct_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: hand-derived vector table, reset corner cases, and randomized
// instruction streams checked against a phase-list reference model.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;

  int n_cmp = 0;
  int n_bad = 0;

  mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ImmSrc,ALUControl,illegal}
  logic [16:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, illegal};

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL} phase_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  phase_t seq_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Whole instruction as a list of phases, decided by the opcode seen at DECODE/MEMADR.
  function automatic void fill_seq(input logic [6:0] o);
    seq_q.delete();
    seq_q.push_back(P_FETCH);
    seq_q.push_back(P_DECODE);
    if (o == LW) begin
      seq_q.push_back(P_MEMADR); seq_q.push_back(P_MEMREAD); seq_q.push_back(P_MEMWB);
    end else if (o == SW) begin
      seq_q.push_back(P_MEMADR); seq_q.push_back(P_MEMWRITE);
    end else if (o == RT) begin
      seq_q.push_back(P_EXECR); seq_q.push_back(P_ALUWB);
    end else if (o == IT) begin
      seq_q.push_back(P_EXECI); seq_q.push_back(P_ALUWB);
    end else if (o == BQ) begin
      seq_q.push_back(P_BEQ);
    end else if (o == JL) begin
      seq_q.push_back(P_JAL); seq_q.push_back(P_ALUWB);
    end
  endfunction

  function automatic logic [16:0] exp_vec(input phase_t p, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic in_rst);
    logic pcw, adr, mw, irw, rw, ill, fill, known;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] ac, fac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; ac = 3'b000;
    known = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    fill = 0;
    case (f3)
      3'b000:  fac = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  fac = 3'b101;
      3'b110:  fac = 3'b011;
      3'b111:  fac = 3'b010;
      default: begin fac = 3'b000; fill = 1; end
    endcase
    case (p)
      P_FETCH:    begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; ill = !known; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXECR:    begin sa = 2'b10; ac = fac; ill = fill; end
      P_EXECI:    begin sa = 2'b10; sb = 2'b01; ac = fac; ill = fill; end
      P_ALUWB:    rw = 1;
      P_BEQ:      begin sa = 2'b10; ac = 3'b001; pcw = z; end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default:    ;
    endcase
    if (in_rst) begin irw = 0; pcw = 0; mw = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, ac, ill};
  endfunction

  // Entered and left at the falling edge of a FETCH cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int chk, output int len,
                           output logic [2:0] ac, output int ill_n,
                           output logic pcw, output logic wr);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    #1;
    len = -1; ac = 3'bxxx; pcw = 1'bx; ill_n = 0; wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (IRWrite) begin len = c; break; end
      end
      if (c == chk) begin ac = ALUControl; pcw = PCWrite; end
      ill_n += int'(illegal);
      wr = wr | RegWrite | MemWrite;
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z; int chk;
    int len; logic [2:0] ac; int ill; logic pcw; logic wr;
  } vec_t;

  vec_t tbl[13];
  logic [6:0] ops[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, ill_n;
    logic [2:0] ac;
    logic pcw, wr;

    tbl[0]  = '{LW, 3'b010, 1'b0, 1'b0, 4, 5, 3'b000, 0, 1'b0, 1'b1};
    tbl[1]  = '{SW, 3'b010, 1'b0, 1'b0, 3, 4, 3'b000, 0, 1'b0, 1'b1};
    tbl[2]  = '{RT, 3'b000, 1'b1, 1'b0, 2, 4, 3'b001, 0, 1'b0, 1'b1};
    tbl[3]  = '{RT, 3'b000, 1'b0, 1'b0, 2, 4, 3'b000, 0, 1'b0, 1'b1};
    tbl[4]  = '{IT, 3'b000, 1'b1, 1'b0, 2, 4, 3'b000, 0, 1'b0, 1'b1};
    tbl[5]  = '{RT, 3'b010, 1'b0, 1'b0, 2, 4, 3'b101, 0, 1'b0, 1'b1};
    tbl[6]  = '{RT, 3'b110, 1'b0, 1'b0, 2, 4, 3'b011, 0, 1'b0, 1'b1};
    tbl[7]  = '{IT, 3'b111, 1'b0, 1'b0, 2, 4, 3'b010, 0, 1'b0, 1'b1};
    tbl[8]  = '{RT, 3'b001, 1'b0, 1'b0, 2, 4, 3'b000, 1, 1'b0, 1'b1};
    tbl[9]  = '{BQ, 3'b000, 1'b0, 1'b1, 2, 3, 3'b001, 0, 1'b1, 1'b0};
    tbl[10] = '{BQ, 3'b000, 1'b0, 1'b0, 2, 3, 3'b001, 0, 1'b0, 1'b0};
    tbl[11] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 1, 2, 3'b000, 1, 1'b0, 1'b0};
    tbl[12] = '{JL, 3'b000, 1'b0, 1'b0, 2, 4, 3'b000, 0, 1'b1, 1'b1};
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;

    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    #12;
    check("reset_outputs", 32'(obs), 32'(17'b0_0_0_0_10_00_10_0_00_000_0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("first_fetch", 32'(obs), 32'(17'b1_0_0_1_10_00_10_0_00_000_0));

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].chk, len, ac, ill_n, pcw, wr);
      check($sformatf("vec%0d_len", i), len, tbl[i].len);
      check($sformatf("vec%0d_alucontrol", i), 32'(ac), 32'(tbl[i].ac));
      check($sformatf("vec%0d_illegal_pulses", i), ill_n, tbl[i].ill);
      check($sformatf("vec%0d_pcwrite", i), 32'(pcw), 32'(tbl[i].pcw));
      check($sformatf("vec%0d_writes", i), 32'(wr), 32'(tbl[i].wr));
    end

    // reset pulse landing in MEMWRITE of a store
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (3) @(negedge clk);
    check("memwrite_before_reset", 32'(MemWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("memwrite_async_drop", 32'(obs), 32'(17'b0_0_0_0_10_00_10_0_01_000_0));
    @(posedge clk); #1;
    check("held_in_reset", 32'(obs), 32'(17'b0_0_0_0_10_00_10_0_01_000_0));
    reset_n = 1'b1;
    @(negedge clk);
    check("fetch_after_reset", 32'(IRWrite), 32'd1);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 4, len, ac, ill_n, pcw, wr);
    check("lw_after_reset_len", len, 5);

    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(6);
      op = (k == 6) ? 7'($urandom_range(127)) : ops[k];
      funct3 = 3'($urandom_range(7));
      funct7b5 = 1'($urandom_range(1));
      Zero = 1'($urandom_range(1));
      fill_seq(op);
      #1;
      for (int s = 0; s < seq_q.size(); s++) begin
        if (s > 0) begin
          @(negedge clk);
          // past MEMADR the opcode must no longer steer the sequence
          if (s >= 3 && $urandom_range(2) == 0) begin
            op = ops[$urandom_range(5)];
            funct3 = 3'($urandom_range(7));
            funct7b5 = 1'($urandom_range(1));
            Zero = 1'($urandom_range(1));
          end
          #1;
        end
        check($sformatf("rand%0d_step%0d", n, s), 32'(obs),
              32'(exp_vec(seq_q[s], op, funct3, funct7b5, Zero, 1'b0)));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
